// File: rtl/pulse_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_seq_pkg
//  Description : Shared types and helpers for the multi-segment pulse
//                sequencer (state encoding, index width, field addressing).
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_seq_pkg;

    // Sequencer control states
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Width of a segment index; a single-segment sequencer still needs one bit
    function automatic int seg_width(input int n_seg);
        return (n_seg > 1) ? $clog2(n_seg) : 1;
    endfunction

    // LSB position of field idx inside a packed vector of equal-width fields
    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_seq_next_seg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_seq_next_seg
//  Description : Combinational priority search for the lowest-index segment
//                with a nonzero duration, starting at (inclusive) or after
//                (exclusive) a given index. No wrap-around; the caller decides
//                what to do when nothing is found.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_seq_next_seg
    import pulse_seq_pkg::*;
#(
    parameter int P_N_WIDTH = 32,
    parameter int P_N_SEG   = 4,
    parameter int P_SEG_W   = 2
) (
    input  logic [P_N_SEG*P_N_WIDTH-1:0] n,
    input  logic [P_SEG_W-1:0]           from_idx,
    input  logic                         inclusive,
    output logic [P_SEG_W-1:0]           next_idx,
    output logic                         valid
);

    // Scan from the top down so the lowest qualifying index is the last writer
    always_comb begin
        next_idx = '0;
        valid    = 1'b0;
        for (int i = P_N_SEG - 1; i >= 0; i--) begin
            if ((int'(from_idx) < i) || (inclusive && (int'(from_idx) == i))) begin
                if (n[field_lsb(i, P_N_WIDTH) +: P_N_WIDTH] != '0) begin
                    next_idx = P_SEG_W'(i);
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pulse_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_seq
//  Description : Multi-segment pulse sequencer. On trigger, plays P_N_SEG
//                segments (duration + level each) from shadow copies of the
//                configuration, repeating the whole pattern n_rpt+1 times.
//                Supports retrigger, abort, segment index and done reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_seq
    import pulse_seq_pkg::*;
#(
    parameter  int P_N_WIDTH   = 32,
    parameter  int P_IO_WIDTH  = 1,
    parameter  int P_N_SEG     = 4,
    parameter  int P_RPT_WIDTH = 8,
    localparam int P_SEG_W     = seg_width(P_N_SEG)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           trig,
    input  logic                           retrig_en,
    input  logic                           abort,
    input  logic [P_N_SEG*P_N_WIDTH-1:0]   n,
    input  logic [P_N_SEG*P_IO_WIDTH-1:0]  a,
    input  logic [P_IO_WIDTH-1:0]          a_idle,
    input  logic [P_RPT_WIDTH-1:0]         n_rpt,
    output logic [P_IO_WIDTH-1:0]          y,
    output logic                           busy,
    output logic [P_SEG_W-1:0]             seg,
    output logic                           done
);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                          r_state;
    logic [P_IO_WIDTH-1:0]           r_y;
    logic [P_SEG_W-1:0]              r_seg;
    logic                            r_done;
    logic [P_N_WIDTH-1:0]            r_cnt;
    logic [P_RPT_WIDTH-1:0]          r_pass;
    logic [P_SEG_W-1:0]              r_first;
    logic [P_N_SEG*P_N_WIDTH-1:0]    r_sh_n;
    logic [P_N_SEG*P_IO_WIDTH-1:0]   r_sh_a;

    // Next-state values
    state_t                          w_state_nxt;
    logic [P_IO_WIDTH-1:0]           w_y_nxt;
    logic [P_SEG_W-1:0]              w_seg_nxt;
    logic                            w_done_nxt;
    logic [P_N_WIDTH-1:0]            w_cnt_nxt;
    logic [P_RPT_WIDTH-1:0]          w_pass_nxt;
    logic [P_SEG_W-1:0]              w_first_nxt;
    logic [P_N_SEG*P_N_WIDTH-1:0]    w_sh_n_nxt;
    logic [P_N_SEG*P_IO_WIDTH-1:0]   w_sh_a_nxt;

    // Search results
    logic [P_SEG_W-1:0]              w_first_idx;
    logic                            w_first_valid;
    logic [P_SEG_W-1:0]              w_next_idx;
    logic                            w_next_valid;

    logic                            w_start;

    // ------------------------------------------------------------------------
    // First nonzero segment of the live inputs: the starting edge must already
    // drive a[first], so the search cannot wait for the shadow copy.
    // ------------------------------------------------------------------------
    pulse_seq_next_seg #(
        .P_N_WIDTH (P_N_WIDTH),
        .P_N_SEG   (P_N_SEG),
        .P_SEG_W   (P_SEG_W)
    ) u_first_seg (
        .n         (n),
        .from_idx  ('0),
        .inclusive (1'b1),
        .next_idx  (w_first_idx),
        .valid     (w_first_valid)
    );

    // Next nonzero segment after the current one, from the shadow config
    pulse_seq_next_seg #(
        .P_N_WIDTH (P_N_WIDTH),
        .P_N_SEG   (P_N_SEG),
        .P_SEG_W   (P_SEG_W)
    ) u_next_seg (
        .n         (r_sh_n),
        .from_idx  (r_seg),
        .inclusive (1'b0),
        .next_idx  (w_next_idx),
        .valid     (w_next_valid)
    );

    // A start request is honoured from IDLE, or while running if retrigger is
    // enabled; abort always wins over a simultaneous trigger.
    assign w_start = trig && !abort && ((r_state == S_IDLE) || retrig_en);

    // ------------------------------------------------------------------------
    // Next-state and output computation
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_seg_nxt   = r_seg;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_pass_nxt  = r_pass;
        w_first_nxt = r_first;
        w_sh_n_nxt  = r_sh_n;
        w_sh_a_nxt  = r_sh_a;

        if (abort) begin
            // Terminate without completion; shadow config is kept as-is
            w_state_nxt = S_IDLE;
            w_y_nxt     = a_idle;
            w_seg_nxt   = '0;
        end else if (w_start) begin
            w_sh_n_nxt  = n;
            w_sh_a_nxt  = a;
            w_pass_nxt  = n_rpt;
            w_first_nxt = w_first_idx;
            if (w_first_valid) begin
                w_state_nxt = S_RUN;
                w_seg_nxt   = w_first_idx;
                w_y_nxt     = a[field_lsb(int'(w_first_idx), P_IO_WIDTH) +: P_IO_WIDTH];
                // Counter holds remaining cycles after the current one
                w_cnt_nxt   = n[field_lsb(int'(w_first_idx), P_N_WIDTH) +: P_N_WIDTH] - 1'b1;
            end else begin
                // Empty pattern: complete immediately without running
                w_state_nxt = S_IDLE;
                w_seg_nxt   = '0;
                w_y_nxt     = a_idle;
                w_done_nxt  = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_y_nxt   = a_idle;
                    w_seg_nxt = '0;
                end
                S_RUN: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else if (w_next_valid) begin
                        // Advance within the pass; zero segments are skipped
                        w_seg_nxt = w_next_idx;
                        w_y_nxt   = r_sh_a[field_lsb(int'(w_next_idx), P_IO_WIDTH) +: P_IO_WIDTH];
                        w_cnt_nxt = r_sh_n[field_lsb(int'(w_next_idx), P_N_WIDTH) +: P_N_WIDTH] - 1'b1;
                    end else if (r_pass != '0) begin
                        // Wrap to the first segment with no idle gap
                        w_pass_nxt = r_pass - 1'b1;
                        w_seg_nxt  = r_first;
                        w_y_nxt    = r_sh_a[field_lsb(int'(r_first), P_IO_WIDTH) +: P_IO_WIDTH];
                        w_cnt_nxt  = r_sh_n[field_lsb(int'(r_first), P_N_WIDTH) +: P_N_WIDTH] - 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_seg_nxt   = '0;
                        w_y_nxt     = a_idle;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_y_nxt     = a_idle;
                    w_seg_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register with synchronous reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_y     <= '0;
            r_seg   <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_pass  <= '0;
            r_first <= '0;
            r_sh_n  <= '0;
            r_sh_a  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_y     <= w_y_nxt;
            r_seg   <= w_seg_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pass  <= w_pass_nxt;
            r_first <= w_first_nxt;
            r_sh_n  <= w_sh_n_nxt;
            r_sh_a  <= w_sh_a_nxt;
        end
    end

    assign y    = r_y;
    assign busy = (r_state == S_RUN);
    assign seg  = r_seg;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pulse_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_seq
//  Description : Directed self-checking bench for pulse_seq (4 segments,
//                4-bit durations, 1-bit level).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_seq;

    localparam int C_NW  = 4;
    localparam int C_IOW = 1;
    localparam int C_NS  = 4;
    localparam int C_RW  = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  trig;
    logic                  retrig_en;
    logic                  abort;
    logic [C_NS*C_NW-1:0]  n;
    logic [C_NS*C_IOW-1:0] a;
    logic [C_IOW-1:0]      a_idle;
    logic [C_RW-1:0]       n_rpt;
    logic [C_IOW-1:0]      y;
    logic                  busy;
    logic [1:0]            seg;
    logic                  done;

    int n_checks = 0;
    int n_errors = 0;

    // Per-run observation record; index j = samples after the starting edge
    int          busy_cnt;
    int          done_cnt;
    int          done_at;
    int          seg1_seen;
    logic [63:0] y_trace;
    int          seg_trace [0:63];

    pulse_seq #(
        .P_N_WIDTH   (C_NW),
        .P_IO_WIDTH  (C_IOW),
        .P_N_SEG     (C_NS),
        .P_RPT_WIDTH (C_RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .retrig_en (retrig_en),
        .abort     (abort),
        .n         (n),
        .a         (a),
        .a_idle    (a_idle),
        .n_rpt     (n_rpt),
        .y         (y),
        .busy      (busy),
        .seg       (seg),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse trig for one edge; returns at the first sample after the start edge
    task automatic trig_once();
        @(posedge clk); #1;
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
    endtask

    // Record outputs for a bounded number of cycles; optionally raise trig or
    // abort after sample trig_at / abort_at so the next edge sees it.
    task automatic observe(input int cycles, input int trig_at, input int abort_at);
        busy_cnt  = 0;
        done_cnt  = 0;
        done_at   = -1;
        seg1_seen = 0;
        y_trace   = '0;
        for (int j = 0; j < cycles; j++) begin
            if (j == trig_at + 1)  trig  = 1'b0;
            if (j == abort_at + 1) abort = 1'b0;
            y_trace[j]   = y[0];
            seg_trace[j] = int'(seg);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (busy && seg == 2'd1) seg1_seen = 1;
            if (j == trig_at)  trig  = 1'b1;
            if (j == abort_at) abort = 1'b1;
            @(posedge clk); #1;
        end
        trig  = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; trig = 1'b0; retrig_en = 1'b0; abort = 1'b0;
        n = '0; a = '0; a_idle = 1'b1; n_rpt = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_y",    32'(y),    32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_seg",  32'(seg),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_follow", 32'(y), 32'd1);
        a_idle = 1'b0;
        @(posedge clk); #1;

        // One-shot: only segment 1 nonzero, 10 cycles high
        n = 16'h00A0; a = 4'b0010; n_rpt = 0;
        trig_once();
        observe(14, -1, -1);
        check("os_y",    y_trace[31:0],     32'h03FF);
        check("os_busy", 32'(busy_cnt),     32'd10);
        check("os_done", 32'(done_cnt),     32'd1);
        check("os_dat",  32'(done_at),      32'd10);
        check("os_seg",  32'(seg_trace[0]), 32'd1);

        // Multi-segment with a skipped zero segment
        n = 16'h2503; a = 4'b0101;
        trig_once();
        observe(12, -1, -1);
        check("ms_y",    y_trace[31:0],      32'h00FF);
        check("ms_busy", 32'(busy_cnt),      32'd10);
        check("ms_dat",  32'(done_at),       32'd10);
        check("ms_seg2", 32'(seg_trace[2]),  32'd0);
        check("ms_seg3", 32'(seg_trace[3]),  32'd2);
        check("ms_seg7", 32'(seg_trace[7]),  32'd2);
        check("ms_seg8", 32'(seg_trace[8]),  32'd3);
        check("ms_segi", 32'(seg_trace[10]), 32'd0);
        check("ms_skip", 32'(seg1_seen),     32'd0);

        // Repeat x3; inputs scrambled mid-run must not matter
        n = 16'h0022; a = 4'b0001; n_rpt = 8'd2;
        trig_once();
        n = '0; a = '0; n_rpt = '0;
        observe(15, -1, -1);
        check("rp_y",    y_trace[31:0],  32'h0333);
        check("rp_busy", 32'(busy_cnt),  32'd12);
        check("rp_dat",  32'(done_at),   32'd12);
        check("rp_done", 32'(done_cnt),  32'd1);

        // Retrigger at cycle 4 of a 10-cycle segment
        n = 16'h000A; a = 4'b0001; n_rpt = 0; retrig_en = 1'b1;
        trig_once();
        observe(17, 3, -1);
        check("rt_y",    y_trace[31:0], 32'h3FFF);
        check("rt_busy", 32'(busy_cnt), 32'd14);
        check("rt_dat",  32'(done_at),  32'd14);
        check("rt_done", 32'(done_cnt), 32'd1);

        // Same with retrigger disabled: second trig ignored
        retrig_en = 1'b0;
        trig_once();
        observe(13, 3, -1);
        check("nr_busy", 32'(busy_cnt), 32'd10);
        check("nr_dat",  32'(done_at),  32'd10);
        check("nr_done", 32'(done_cnt), 32'd1);

        // Abort at cycle 3
        a_idle = 1'b0;
        trig_once();
        observe(8, -1, 2);
        check("ab_y",    y_trace[31:0], 32'h0007);
        check("ab_busy", 32'(busy_cnt), 32'd3);
        check("ab_done", 32'(done_cnt), 32'd0);

        // Abort and trig together from IDLE
        @(posedge clk); #1;
        trig = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0; abort = 1'b0;
        observe(4, -1, -1);
        check("at_busy", 32'(busy_cnt), 32'd0);
        check("at_done", 32'(done_cnt), 32'd0);

        // All durations zero
        n = '0; a = 4'b1111;
        trig_once();
        observe(4, -1, -1);
        check("z_busy", 32'(busy_cnt),   32'd0);
        check("z_done", 32'(done_cnt),   32'd1);
        check("z_dat",  32'(done_at),    32'd0);
        check("z_y",    y_trace[31:0],   32'h0000);

        // Maximum duration 15
        n = 16'h000F; a = 4'b0001;
        trig_once();
        observe(18, -1, -1);
        check("mx_y",    y_trace[31:0], 32'h7FFF);
        check("mx_busy", 32'(busy_cnt), 32'd15);
        check("mx_dat",  32'(done_at),  32'd15);

        // Back-to-back: trig in the done cycle restarts after a 1-cycle gap
        n = 16'h0002;
        trig_once();
        observe(8, 2, -1);
        check("bb_y",    y_trace[31:0], 32'h001B);
        check("bb_busy", 32'(busy_cnt), 32'd4);
        check("bb_done", 32'(done_cnt), 32'd2);

        // Reset mid-run
        n = 16'h000A; a = 4'b0001; a_idle = 1'b1;
        trig_once();
        observe(3, -1, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mr_y",    32'(y),    32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_seg",  32'(seg),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mr_idle", 32'(y),    32'd1);
        check("mr_nb",   32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_seq.md
# pulse_seq

Parametrised multi-segment pulse sequencer, the next generation of the two-level one-shot. On a trigger it plays P_N_SEG programmable segments, each with its own duration and output level. The whole pattern repeats a programmable number of times. Supports retrigger and abort, and reports segment index and completion. Used wherever timed gate/strobe trains are needed, such as DAC strobes, calibration pulses and bias ramps.

## Interface
- P_N_WIDTH, 32, width of each segment duration count
- P_IO_WIDTH, 1, width of output level y
- P_N_SEG, 4, number of segments (≥1)
- P_RPT_WIDTH, 8, width of repeat count
- P_SEG_W, $clog2(P_N_SEG) min 1, width of seg (localparam)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- trig  in  1  start request, level-sampled each cycle
- retrig_en  in  1  1: trig while busy restarts sequence; 0: ignored
- abort  in  1  terminate sequence, no done
- n  in  P_N_SEG*P_N_WIDTH  segment durations, seg i at [i*P_N_WIDTH +: P_N_WIDTH]; 0 = skip
- a  in  P_N_SEG*P_IO_WIDTH  segment output levels, same packing
- a_idle  in  P_IO_WIDTH  output level when not running
- n_rpt  in  P_RPT_WIDTH  extra passes; sequence plays n_rpt+1 times
- y  out  P_IO_WIDTH  registered output level
- busy  out  1  sequence in progress
- seg  out  P_SEG_W  index of segment currently driving y (0 when idle)
- done  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, RUN.
- IDLE: y <= a_idle each cycle, busy=0, seg=0.
- Start: trig=1 in IDLE, or in RUN with retrig_en=1.
  - n, a and n_rpt are latched into shadow registers.
  - Pattern runs from shadow registers only; input changes mid-sequence have no effect.
- First segment is the lowest index i with n[i]≠0.
  - If all n are zero: no RUN; done pulses next cycle; y stays a_idle; busy stays 0.
- RUN: y=a[seg] for exactly n[seg] cycles.
  - Then advance to the next nonzero segment. Zero segments consume zero cycles (priority find-next).
  - After the last nonzero segment, if passes remain: decrement pass count and wrap to the first nonzero segment with no gap.
  - Otherwise: go to IDLE, y <= a_idle, done=1.
- Abort (priority over trig): go to IDLE next edge; y <= a_idle; no done; shadow registers are not cleared.
- Simultaneous trig and abort: abort wins; trig is dropped.
- Retrigger in RUN: restart at the first nonzero segment with the new config and full repeat count; no done for the interrupted sequence.
- trig in RUN with retrig_en=0: ignored; not queued.
- Duration counter is P_N_WIDTH down-counter. n=2^P_N_WIDTH−1 must time exactly, with no overflow.
- Reset: y=0, busy=0, done=0, seg=0, state IDLE.
  - From the first cycle after reset, y follows a_idle.
  - Reset mid-sequence aborts immediately.

## Timing
- trig sampled high at edge k: at edge k, busy=1 and y=a[first]. Latency 1 clock from trig assertion.
- Segment i occupies exactly n[i] clocks.
- Total busy time is (n_rpt+1)·Σn[i] clocks.
- done and busy↓ and y=a_idle all occur at the same edge after the final cycle of the last segment.
- done is high exactly 1 cycle.
- Back-to-back: trig high in the done cycle starts a new sequence at the next edge. Minimum idle gap is 1 cycle.
- seg changes on the same edge as y.

## Structure
- Shared package pulse_seq_pkg:
  - state enum {IDLE, RUN}
  - helper function for packed-field extraction
  - P_SEG_W computation
- Sub-module pulse_seq_next_seg: combinational. Given shadow n and a current index, returns the next nonzero index and a valid flag (wrap handled by caller). It is reused for first-segment search.
- Top contains the FSM, shadow registers, duration counter and pass counter.

## Test plan
- One-shot equivalence: P_N_SEG=2, n={0,10}, a={0,1}, a_idle=0, n_rpt=0, trig pulse → y=1 for exactly 10 cycles starting 1 edge after trig; busy for 10 cycles; done once.
- Multi-segment/skip: n={3,0,5,2}, a={1,0,1,0} (P_IO_WIDTH=1) → y pattern 1×3, 1×5, 0×2; seg goes 0,2,3; segment 1 never shown.
- Repeat: n={2,2}, a={1,0}, n_rpt=2 → 1,1,0,0 repeated 3 times, contiguous; busy 12 cycles; done at cycle 12.
- Retrigger: retrig_en=1, trig again at cycle 4 of a 10-cycle segment → restart, y held a[0] 10 more cycles, single done. With retrig_en=0 → second trig ignored, busy ends at cycle 10.
- Abort/simultaneous: abort at cycle 3 → y=a_idle next edge, busy=0, done never asserted. Abort and trig same cycle → stays IDLE.
- Boundaries:
  - all n=0 → done 1 cycle after trig, busy never high.
  - P_N_WIDTH=4, n=15 → exactly 15 cycles.
  - rst asserted mid-RUN → y=0, busy=0 next edge.
